// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU operand select, condition codes, E/M pipeline register.
// Latency: one cycle from decode inputs to registered E/M outputs.
// Backpressure: stall holds E/M and CC; bubble (without stall) injects a nop and holds CC.

// 64-bit ALU: add, sub (a - b), and, xor with signed overflow for add/sub.
module alu (
  input  logic [1:0]  control,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] ans,
  output logic        overflow
);

  // Compute result and two's complement overflow for the selected op
  always_comb begin
    ans      = '0;
    overflow = 1'b0;
    case (control)
      2'b00: begin
        ans      = a + b;
        overflow = (a[63] == b[63]) && (ans[63] != a[63]);
      end
      2'b01: begin
        ans      = a - b;
        overflow = (a[63] != b[63]) && (ans[63] != a[63]);
      end
      2'b10:   ans = a & b;
      default: ans = a ^ b;
    endcase
  end

endmodule

module execute_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [3:0]  in_icode,
  input  logic [3:0]  in_ifun,
  input  logic [63:0] in_valA,
  input  logic [63:0] in_valB,
  input  logic [63:0] in_valC,
  input  logic [3:0]  in_dstE,
  input  logic [3:0]  in_dstM,
  input  logic        stall,
  input  logic        bubble,
  input  logic        set_cc_en,
  output logic        out_valid,
  output logic [3:0]  out_icode,
  output logic        out_cnd,
  output logic [63:0] out_valE,
  output logic [63:0] out_valA,
  output logic [3:0]  out_dstE,
  output logic [3:0]  out_dstM,
  output logic        cc_zf,
  output logic        cc_sf,
  output logic        cc_of
);

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] REG_NONE = 4'hF;

  localparam logic [1:0] ALU_ADD = 2'b00;

  typedef struct packed {
    logic        valid;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } em_t;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam em_t EM_NOP = '{
    valid: 1'b0, icode: I_NOP, cnd: 1'b0, valE: 64'd0,
    valA: 64'd0, dstE: REG_NONE, dstM: REG_NONE
  };
  localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

  em_t em_q, em_d;
  cc_t cc_q, cc_d;

  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [1:0]  alu_ctl;
  logic [63:0] alu_ans;
  logic        alu_ovf;
  logic        cond_true;
  logic        cnd_eff;
  logic        cc_wr;

  // Pick ALU operands and function from the instruction class
  always_comb begin
    alu_a   = 64'd0;
    alu_b   = 64'd0;
    alu_ctl = ALU_ADD;
    case (in_icode)
      I_OPQ: begin
        alu_a   = in_valA;
        alu_b   = in_valB;
        alu_ctl = in_ifun[1:0];
      end
      I_RRMOVQ:          alu_a = in_valA;
      I_IRMOVQ:          alu_a = in_valC;
      I_RMMOVQ, I_MRMOVQ: begin
        alu_a = in_valC;
        alu_b = in_valB;
      end
      I_CALL, I_PUSHQ: begin
        alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
        alu_b = in_valB;
      end
      I_RET, I_POPQ: begin
        alu_a = 64'd8;
        alu_b = in_valB;
      end
      default: ;
    endcase
  end

  // The ALU subtracts its b port from a, so aluB goes to a to get aluB - aluA
  alu u_alu (
    .control  (alu_ctl),
    .a        (alu_b),
    .b        (alu_a),
    .ans      (alu_ans),
    .overflow (alu_ovf)
  );

  // Evaluate the branch/move condition against the flags held before this instruction
  always_comb begin
    cond_true = 1'b0;
    case (in_ifun)
      4'h0:    cond_true = 1'b1;
      4'h1:    cond_true = (cc_q.sf ^ cc_q.of) | cc_q.zf;
      4'h2:    cond_true = cc_q.sf ^ cc_q.of;
      4'h3:    cond_true = cc_q.zf;
      4'h4:    cond_true = ~cc_q.zf;
      4'h5:    cond_true = ~(cc_q.sf ^ cc_q.of);
      4'h6:    cond_true = ~(cc_q.sf ^ cc_q.of) & ~cc_q.zf;
      default: cond_true = 1'b0;
    endcase
  end

  // Only conditional moves and jumps carry a condition outcome downstream
  assign cnd_eff = ((in_icode == I_RRMOVQ) || (in_icode == I_JXX)) ? cond_true : 1'b0;

  // Flags change only for a real OPq that actually advances and is not squashed
  assign cc_wr = in_valid && (in_icode == I_OPQ) && !stall && !bubble && set_cc_en;

  // Next condition-code value; logical ops never report overflow
  always_comb begin
    cc_d = cc_q;
    if (cc_wr) begin
      cc_d.zf = (alu_ans == 64'd0);
      cc_d.sf = alu_ans[63];
      cc_d.of = in_ifun[1] ? 1'b0 : alu_ovf;
    end
  end

  // Next E/M contents: stall holds, bubble or empty slot loads a nop, else load results
  always_comb begin
    em_d = em_q;
    if (!stall) begin
      if (bubble || !in_valid) begin
        em_d = EM_NOP;
      end else begin
        em_d.valid = 1'b1;
        em_d.icode = in_icode;
        em_d.cnd   = cnd_eff;
        em_d.valE  = alu_ans;
        em_d.valA  = in_valA;
        em_d.dstE  = ((in_icode == I_RRMOVQ) && !cnd_eff) ? REG_NONE : in_dstE;
        em_d.dstM  = in_dstM;
      end
    end
  end

  // E/M and CC registers; reset clears them immediately to the nop/initial-flag state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      em_q <= EM_NOP;
      cc_q <= CC_RESET;
    end else begin
      em_q <= em_d;
      cc_q <= cc_d;
    end
  end

  assign out_valid = em_q.valid;
  assign out_icode = em_q.icode;
  assign out_cnd   = em_q.cnd;
  assign out_valE  = em_q.valE;
  assign out_valA  = em_q.valA;
  assign out_dstE  = em_q.dstE;
  assign out_dstM  = em_q.dstM;
  assign cc_zf     = cc_q.zf;
  assign cc_sf     = cc_q.sf;
  assign cc_of     = cc_q.of;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed scenarios plus randomized instruction stream.
// Expected values come from an instruction-level reference model kept here.
// Inputs change 1ns after each rising edge; outputs are sampled at that same point.

module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_icode;
  logic [3:0]  in_ifun;
  logic [63:0] in_valA;
  logic [63:0] in_valB;
  logic [63:0] in_valC;
  logic [3:0]  in_dstE;
  logic [3:0]  in_dstM;
  logic        stall;
  logic        bubble;
  logic        set_cc_en;
  logic        out_valid;
  logic [3:0]  out_icode;
  logic        out_cnd;
  logic [63:0] out_valE;
  logic [63:0] out_valA;
  logic [3:0]  out_dstE;
  logic [3:0]  out_dstM;
  logic        cc_zf;
  logic        cc_sf;
  logic        cc_of;

  execute_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_icode  (in_icode),
    .in_ifun   (in_ifun),
    .in_valA   (in_valA),
    .in_valB   (in_valB),
    .in_valC   (in_valC),
    .in_dstE   (in_dstE),
    .in_dstM   (in_dstM),
    .stall     (stall),
    .bubble    (bubble),
    .set_cc_en (set_cc_en),
    .out_valid (out_valid),
    .out_icode (out_icode),
    .out_cnd   (out_cnd),
    .out_valE  (out_valE),
    .out_valA  (out_valA),
    .out_dstE  (out_dstE),
    .out_dstM  (out_dstM),
    .cc_zf     (cc_zf),
    .cc_sf     (cc_sf),
    .cc_of     (cc_of)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: what the E/M register and flags should hold
  logic        m_valid;
  logic [3:0]  m_icode;
  logic        m_cnd;
  logic [63:0] m_valE;
  logic [63:0] m_valA;
  logic [3:0]  m_dstE;
  logic [3:0]  m_dstM;
  logic        m_zf;
  logic        m_sf;
  logic        m_of;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic cond_holds(input logic [3:0] fn, input logic zf,
                                      input logic sf, input logic of);
    case (fn)
      4'h0:    return 1'b1;
      4'h1:    return (sf != of) || zf;
      4'h2:    return sf != of;
      4'h3:    return zf;
      4'h4:    return !zf;
      4'h5:    return sf == of;
      4'h6:    return (sf == of) && !zf;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_icode = 4'h1; m_cnd = 1'b0;
    m_valE = 64'd0; m_valA = 64'd0; m_dstE = 4'hF; m_dstM = 4'hF;
    m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
  endtask

  // Apply one clock edge's worth of instruction semantics to the model
  task automatic model_edge();
    logic [63:0]        res;
    logic               ovf;
    logic               c;
    logic signed [65:0] wide;
    if (stall) return;
    if (bubble || !in_valid) begin
      m_valid = 1'b0; m_icode = 4'h1; m_cnd = 1'b0;
      m_valE = 64'd0; m_valA = 64'd0; m_dstE = 4'hF; m_dstM = 4'hF;
      return;
    end
    res  = 64'd0;
    ovf  = 1'b0;
    wide = '0;
    case (in_icode)
      4'h6: begin
        case (in_ifun[1:0])
          2'd0: begin
            wide = $signed({{2{in_valB[63]}}, in_valB}) + $signed({{2{in_valA[63]}}, in_valA});
            res  = wide[63:0];
            ovf  = (wide != $signed({{2{wide[63]}}, wide[63:0]}));
          end
          2'd1: begin
            wide = $signed({{2{in_valB[63]}}, in_valB}) - $signed({{2{in_valA[63]}}, in_valA});
            res  = wide[63:0];
            ovf  = (wide != $signed({{2{wide[63]}}, wide[63:0]}));
          end
          2'd2: res = in_valB & in_valA;
          default: res = in_valB ^ in_valA;
        endcase
      end
      4'h2:       res = in_valA;
      4'h3:       res = in_valC;
      4'h4, 4'h5: res = in_valC + in_valB;
      4'h8, 4'hA: res = in_valB - 64'd8;
      4'h9, 4'hB: res = in_valB + 64'd8;
      default:    res = 64'd0;
    endcase
    c = cond_holds(in_ifun, m_zf, m_sf, m_of);
    m_valid = 1'b1;
    m_icode = in_icode;
    m_cnd   = (in_icode == 4'h2 || in_icode == 4'h7) ? c : 1'b0;
    m_valE  = res;
    m_valA  = in_valA;
    m_dstE  = (in_icode == 4'h2 && !c) ? 4'hF : in_dstE;
    m_dstM  = in_dstM;
    if (in_icode == 4'h6 && set_cc_en) begin
      m_zf = (res == 64'd0);
      m_sf = res[63];
      m_of = ovf;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, 64'(out_valid), 64'(m_valid));
    check({tag, ".icode"}, 64'(out_icode), 64'(m_icode));
    check({tag, ".cnd"},   64'(out_cnd),   64'(m_cnd));
    check({tag, ".valE"},  out_valE,       m_valE);
    check({tag, ".valA"},  out_valA,       m_valA);
    check({tag, ".dstE"},  64'(out_dstE),  64'(m_dstE));
    check({tag, ".dstM"},  64'(out_dstM),  64'(m_dstM));
    check({tag, ".zf"},    64'(cc_zf),     64'(m_zf));
    check({tag, ".sf"},    64'(cc_sf),     64'(m_sf));
    check({tag, ".of"},    64'(cc_of),     64'(m_of));
  endtask

  task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                       input logic [3:0] de, input logic [3:0] dm);
    in_valid = v; in_icode = ic; in_ifun = fn;
    in_valA = a; in_valB = b; in_valC = c;
    in_dstE = de; in_dstM = dm;
    stall = 1'b0; bubble = 1'b0; set_cc_en = 1'b1;
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  function automatic logic [63:0] rand64();
    case ($urandom_range(0, 6))
      0:       return 64'd0;
      1:       return 64'h7FFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'(signed'(32'($urandom_range(0, 16)) - 32'd8));
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // add 1 + 2
    drive(1'b1, 4'h6, 4'h0, 64'd1, 64'd2, 64'd0, 4'h3, 4'hF);
    tick("add");
    check("add_lit.valE", out_valE, 64'd3);
    check("add_lit.zf", 64'(cc_zf), 64'd0);

    // signed overflow on add
    drive(1'b1, 4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h3, 4'hF);
    tick("add_ovf");
    check("add_ovf_lit.valE", out_valE, 64'h8000_0000_0000_0000);
    check("add_ovf_lit.of", 64'(cc_of), 64'd1);
    check("add_ovf_lit.sf", 64'(cc_sf), 64'd1);

    // sub to zero, then cmovne sees ZF=1 and is suppressed
    drive(1'b1, 4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h3, 4'hF);
    tick("sub_zero");
    check("sub_zero_lit.zf", 64'(cc_zf), 64'd1);
    drive(1'b1, 4'h2, 4'h4, 64'd77, 64'd0, 64'd0, 4'h3, 4'hF);
    tick("cmovne");
    check("cmovne_lit.cnd", 64'(out_cnd), 64'd0);
    check("cmovne_lit.dstE", 64'(out_dstE), 64'hF);

    // stack pointer arithmetic leaves flags alone
    drive(1'b1, 4'hA, 4'h0, 64'd9, 64'h100, 64'd0, 4'h4, 4'hF);
    tick("pushq");
    check("pushq_lit.valE", out_valE, 64'hF8);
    check("pushq_lit.zf", 64'(cc_zf), 64'd1);
    drive(1'b1, 4'hB, 4'h0, 64'd9, 64'h100, 64'd0, 4'h4, 4'h2);
    tick("popq");
    check("popq_lit.valE", out_valE, 64'h108);

    // xor held off by a two-cycle stall
    drive(1'b1, 4'h6, 4'h3, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 64'd0, 4'h5, 4'hF);
    stall = 1'b1;
    tick("stall1");
    tick("stall2");
    check("stall_lit.icode", 64'(out_icode), 64'hB);
    stall = 1'b0;
    tick("xor");
    check("xor_lit.valE", out_valE, 64'hFFFF_FFFF_FFFF_FFFF);
    check("xor_lit.sf", 64'(cc_sf), 64'd1);
    check("xor_lit.of", 64'(cc_of), 64'd0);

    // stall beats bubble; bubble alone injects a nop
    drive(1'b1, 4'h6, 4'h0, 64'd4, 64'd4, 64'd0, 4'h1, 4'hF);
    stall = 1'b1; bubble = 1'b1;
    tick("stall_bubble");
    check("stall_bubble_lit.icode", 64'(out_icode), 64'h6);
    stall = 1'b0;
    tick("bubble");
    check("bubble_lit.icode", 64'(out_icode), 64'h1);
    check("bubble_lit.valid", 64'(out_valid), 64'd0);

    // asynchronous reset between edges discards the in-flight instruction
    drive(1'b1, 4'h6, 4'h0, 64'd1, 64'd2, 64'd0, 4'h2, 4'hF);
    tick("pre_rst");
    check("pre_rst_lit.valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #2;
    model_reset();
    check_all("rst_async");
    check("rst_lit.icode", 64'(out_icode), 64'h1);
    #2;
    rst = 1'b0;
    tick("post_rst");
    check("post_rst_lit.valid", 64'(out_valid), 64'd1);

    // flag writes blocked by set_cc_en=0
    drive(1'b1, 4'h6, 4'h0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 4'h2, 4'hF);
    set_cc_en = 1'b0;
    tick("no_cc");
    check("no_cc_lit.zf", 64'(cc_zf), 64'd0);

    // randomized instruction stream
    for (int i = 0; i < 400; i++) begin
      logic [3:0] ic;
      logic [3:0] fn;
      logic [63:0] a;
      logic [63:0] b;
      ic = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(2, 11));
      fn = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
      a  = rand64();
      b  = ($urandom_range(0, 7) == 0) ? a : rand64();
      drive(($urandom_range(0, 9) != 0), ic, fn, a, b, rand64(),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      stall     = ($urandom_range(0, 9) == 0);
      bubble    = ($urandom_range(0, 9) == 0);
      set_cc_en = ($urandom_range(0, 7) != 0);
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
